// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - shared processor constants for the instruction fetch path
package processor_pkg;

    // Fetch FSM encoding, kept as plain constants for legacy tools.
    localparam logic [2:0] FETCH_IDLE  = 3'd0;
    localparam logic [2:0] FETCH_ISSUE = 3'd1;
    localparam logic [2:0] FETCH_WAIT  = 3'd2;
    localparam logic [2:0] FETCH_HOLD  = 3'd3;
    localparam logic [2:0] FETCH_FAULT = 3'd4;

    localparam int INSTR_BYTES = 4;

    // addi x0, x0, 0 - bubble instruction for the processor top level.
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Instruction memory read latency supported by the fetch unit.
    localparam int MEM_LATENCY_MIN = 1;
    localparam int MEM_LATENCY_MAX = 2;

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter with redirect load, +4 increment and alignment check
// Ports:
//   clk, rst    clock, asynchronous active-high reset (pc returns to RESET_PC)
//   load        load load_pc into pc (takes priority over incr)
//   load_pc     redirect target
//   incr        advance pc by one instruction
//   pc          current program counter
//   misaligned  combinational strobe: load with a target that is not 4-byte aligned
module fetch_pc_reg
    import processor_pkg::*;
#(
    parameter int                   WORD_SIZE = 32,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [WORD_SIZE-1:0] load_pc,
    input  logic                 incr,
    output logic [WORD_SIZE-1:0] pc,
    output logic                 misaligned
);

    assign misaligned = load && (load_pc[1:0] != 2'b00);

    // A misaligned target is still loaded so the faulting address is retained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc;
        end else if (incr) begin
            pc <= pc + WORD_SIZE'(INSTR_BYTES);
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetches instructions from synchronous memory and hands them to decode
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   fetch_en                  permits new fetches to start
//   mem_address, mem_rden     word address / read strobe to instruction memory
//   mem_q                     memory read data, valid MEM_LATENCY cycles after the read strobe
//   instr, instr_pc           captured instruction and its byte address
//   instr_valid, instr_ready  handshake with the decode stage
//   redirect, redirect_pc     one-cycle pulse loading a new pc
//   misaligned                sticky flag: redirect to a non-aligned target
//   fetch_busy                a memory read is issued or in flight
module instruction_fetch_unit
    import processor_pkg::*;
#(
    parameter int                   WORD_SIZE   = 32,
    parameter int                   ADDR_WIDTH  = 16,
    parameter logic [WORD_SIZE-1:0] RESET_PC    = '0,
    parameter int                   MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_rden,
    input  logic [WORD_SIZE-1:0]  mem_q,
    output logic [WORD_SIZE-1:0]  instr,
    output logic [WORD_SIZE-1:0]  instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  redirect,
    input  logic [WORD_SIZE-1:0]  redirect_pc,
    output logic                  misaligned,
    output logic                  fetch_busy
);

    // Anything other than the minimum latency is treated as the two-cycle memory.
    localparam logic [1:0] LAT = (MEM_LATENCY <= MEM_LATENCY_MIN) ? 2'd1 : 2'd2;

    logic [2:0]            state;
    logic [2:0]            state_d;
    logic [1:0]            lat_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WORD_SIZE-1:0]  pc;
    logic                  pc_misaligned;
    logic                  redirect_ok;
    logic                  capture;
    logic                  handshake;

    // FAULT is terminal until reset, so redirects are ignored there.
    assign redirect_ok = redirect && (state != FETCH_FAULT);

    // A redirect in the capture cycle discards the returning word.
    assign capture   = (state == FETCH_WAIT) && (lat_cnt == 2'd1) && !redirect_ok;
    assign handshake = (state == FETCH_HOLD) && instr_valid && instr_ready;

    fetch_pc_reg #(
        .WORD_SIZE (WORD_SIZE),
        .RESET_PC  (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst        (rst),
        .load       (redirect_ok),
        .load_pc    (redirect_pc),
        .incr       (capture),
        .pc         (pc),
        .misaligned (pc_misaligned)
    );

    always_comb begin
        state_d = state;
        case (state)
            FETCH_IDLE:  if (fetch_en) state_d = FETCH_ISSUE;
            FETCH_ISSUE: state_d = FETCH_WAIT;
            FETCH_WAIT:  if (lat_cnt == 2'd1) state_d = FETCH_HOLD;
            FETCH_HOLD:  if (handshake) state_d = fetch_en ? FETCH_ISSUE : FETCH_IDLE;
            FETCH_FAULT: state_d = FETCH_FAULT;
            default:     state_d = FETCH_IDLE;
        endcase
        if (redirect_ok) begin
            state_d = pc_misaligned ? FETCH_FAULT : (fetch_en ? FETCH_ISSUE : FETCH_IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH_IDLE;
            lat_cnt     <= 2'd0;
            addr_q      <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            misaligned  <= 1'b0;
        end else begin
            state <= state_d;

            if (state == FETCH_ISSUE) begin
                lat_cnt <= LAT;
                addr_q  <= pc[ADDR_WIDTH+1:2];
            end else if ((state == FETCH_WAIT) && (lat_cnt != 2'd0)) begin
                lat_cnt <= lat_cnt - 2'd1;
            end

            if (capture) begin
                instr       <= mem_q;
                instr_pc    <= pc;
                instr_valid <= 1'b1;
            end else if (redirect_ok || handshake) begin
                instr_valid <= 1'b0;
            end

            if (redirect_ok && pc_misaligned) begin
                misaligned <= 1'b1;
            end
        end
    end

    // Address is driven live during ISSUE and then parked on the last issued word.
    assign mem_address = (state == FETCH_ISSUE) ? pc[ADDR_WIDTH+1:2] : addr_q;
    assign mem_rden    = (state == FETCH_ISSUE);
    assign fetch_busy  = (state == FETCH_ISSUE) || (state == FETCH_WAIT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    // Unit A: latency 1, reset pc 0
    logic        fetch_en = 1'b0, instr_ready = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [15:0] mem_address;
    logic        mem_rden, instr_valid, misaligned, fetch_busy;
    logic [31:0] mem_q, instr, instr_pc;

    // Unit B: latency 2
    logic        fetch_en_b = 1'b0, instr_ready_b = 1'b0, redirect_b = 1'b0;
    logic [31:0] redirect_pc_b = 32'h0;
    logic [15:0] mem_address_b;
    logic        mem_rden_b, instr_valid_b, misaligned_b, fetch_busy_b;
    logic [31:0] mem_q_b, instr_b, instr_pc_b, stage_b;

    // Unit C: reset pc at the top of the memory window
    logic        fetch_en_c = 1'b0, instr_ready_c = 1'b0, redirect_c = 1'b0;
    logic [31:0] redirect_pc_c = 32'h0;
    logic [15:0] mem_address_c;
    logic        mem_rden_c, instr_valid_c, misaligned_c, fetch_busy_c;
    logic [31:0] mem_q_c, instr_c, instr_pc_c;

    instruction_fetch_unit #(.MEM_LATENCY(1)) u_dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .mem_address(mem_address), .mem_rden(mem_rden),
        .mem_q(mem_q), .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
        .misaligned(misaligned), .fetch_busy(fetch_busy));

    instruction_fetch_unit #(.MEM_LATENCY(2)) u_dut_b (
        .clk(clk), .rst(rst), .fetch_en(fetch_en_b), .mem_address(mem_address_b), .mem_rden(mem_rden_b),
        .mem_q(mem_q_b), .instr(instr_b), .instr_pc(instr_pc_b), .instr_valid(instr_valid_b),
        .instr_ready(instr_ready_b), .redirect(redirect_b), .redirect_pc(redirect_pc_b),
        .misaligned(misaligned_b), .fetch_busy(fetch_busy_b));

    instruction_fetch_unit #(.MEM_LATENCY(1), .RESET_PC(32'h0003_FFFC)) u_dut_c (
        .clk(clk), .rst(rst), .fetch_en(fetch_en_c), .mem_address(mem_address_c), .mem_rden(mem_rden_c),
        .mem_q(mem_q_c), .instr(instr_c), .instr_pc(instr_pc_c), .instr_valid(instr_valid_c),
        .instr_ready(instr_ready_c), .redirect(redirect_c), .redirect_pc(redirect_pc_c),
        .misaligned(misaligned_c), .fetch_busy(fetch_busy_c));

    logic [31:0] mem [0:65535];

    always @(posedge clk) if (mem_rden) mem_q <= mem[mem_address];
    always @(posedge clk) begin
        if (mem_rden_b) stage_b <= mem[mem_address_b];
        mem_q_b <= stage_b;
    end
    always @(posedge clk) if (mem_rden_c) mem_q_c <= mem[mem_address_c];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
    exp_t exp_q[$];

    // Handshakes on unit A, sampled just before the edge that completes them.
    logic [31:0] got_pc [0:63];
    logic [31:0] got_instr [0:63];
    int hs_cnt = 0;
    int rd_idx = 0;

    always @(negedge clk) begin
        #2;
        if (!rst && instr_valid && instr_ready && hs_cnt < 64) begin
            got_pc[hs_cnt] = instr_pc;
            got_instr[hs_cnt] = instr;
            hs_cnt = hs_cnt + 1;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fetch_en = 1'b0; fetch_en_b = 1'b0; fetch_en_c = 1'b0;
        instr_ready = 1'b0; instr_ready_b = 1'b0; instr_ready_c = 1'b0;
        redirect = 1'b0; redirect_pc = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        rd_idx = hs_cnt;
        exp_q.delete();
        tick();
    endtask

    task automatic wait_hs(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (hs_cnt > rd_idx) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (instr_valid) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        bit ok;
        rst = 1'b1;
        fetch_en = 1'b1;
        tick();
        tick();
        total_cnt++; if (instr !== 32'h0) $display("FAIL reset_instr got=%h exp=%h", instr, 32'h0); else pass_cnt++;
        total_cnt++; if (instr_pc !== 32'h0) $display("FAIL reset_instr_pc got=%h exp=%h", instr_pc, 32'h0); else pass_cnt++;
        total_cnt++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", instr_valid); else pass_cnt++;
        total_cnt++; if (mem_address !== 16'h0) $display("FAIL reset_mem_address got=%h exp=0000", mem_address); else pass_cnt++;
        total_cnt++; if (mem_rden !== 1'b0) $display("FAIL reset_mem_rden got=%b exp=0", mem_rden); else pass_cnt++;
        total_cnt++; if (misaligned !== 1'b0) $display("FAIL reset_misaligned got=%b exp=0", misaligned); else pass_cnt++;
        total_cnt++; if (fetch_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", fetch_busy); else pass_cnt++;
        total_cnt++; if (instr_valid_b !== 1'b0) $display("FAIL reset_valid_b got=%b exp=0", instr_valid_b); else pass_cnt++;
        total_cnt++; if (mem_address_c !== 16'h0) $display("FAIL reset_mem_address_c got=%h exp=0000", mem_address_c); else pass_cnt++;
        // Reset while a read is in flight: the late data must never appear.
        rst = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_rden) begin ok = 1'b1; break; end
        end
        total_cnt++; if (!ok) $display("FAIL reset_midfetch_issue got=none exp=issue"); else pass_cnt++;
        tick();
        rst = 1'b1;
        #1;
        total_cnt++; if (fetch_busy !== 1'b0) $display("FAIL reset_midfetch_busy got=%b exp=0", fetch_busy); else pass_cnt++;
        tick();
        fetch_en = 1'b0;
        rst = 1'b0;
        repeat (3) tick();
        total_cnt++; if (instr_valid !== 1'b0 || instr !== 32'h0)
            $display("FAIL reset_midfetch_discard got=%b/%h exp=0/00000000", instr_valid, instr); else pass_cnt++;
    endtask

    task automatic test_stream_l1();
        bit ok;
        int t_issue, t_valid;
        exp_t e;
        do_reset();
        exp_q.push_back('{32'h0, 32'h0050_0093});
        exp_q.push_back('{32'h4, 32'h00A0_0113});
        exp_q.push_back('{32'h8, 32'h0020_81B3});
        fetch_en = 1'b1;
        instr_ready = 1'b1;
        t_issue = -100;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_rden) begin t_issue = cyc; break; end
        end
        wait_valid(10, ok);
        t_valid = cyc;
        total_cnt++; if (!ok || (t_valid - t_issue) != 2)
            $display("FAIL l1_latency got=%0d exp=2", t_valid - t_issue); else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            wait_hs(20, ok);
            total_cnt++; if (!ok) $display("FAIL stream_hs%0d got=timeout exp=handshake", k); else pass_cnt++;
            if (ok) begin
                e = exp_q.pop_front();
                total_cnt++; if (got_instr[rd_idx] !== e.data) $display("FAIL stream_instr%0d got=%h exp=%h", k, got_instr[rd_idx], e.data); else pass_cnt++;
                total_cnt++; if (got_pc[rd_idx] !== e.pc) $display("FAIL stream_pc%0d got=%h exp=%h", k, got_pc[rd_idx], e.pc); else pass_cnt++;
                rd_idx++;
            end
        end
        fetch_en = 1'b0;
        instr_ready = 1'b0;
        repeat (4) tick();
        total_cnt++; if (hs_cnt != rd_idx) $display("FAIL stream_extra got=%0d exp=%0d", hs_cnt, rd_idx); else pass_cnt++;
    endtask

    task automatic test_stall_hold();
        bit ok;
        int bad;
        exp_t e;
        do_reset();
        exp_q.push_back('{32'h0, 32'h0050_0093});
        exp_q.push_back('{32'h4, 32'h00A0_0113});
        fetch_en = 1'b1;
        wait_valid(10, ok);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (k == 1) begin
                wait_valid(10, ok);
                bad = 0;
                for (int c = 0; c < 5; c++) begin
                    if (instr !== 32'h00A0_0113 || instr_pc !== 32'h4 || instr_valid !== 1'b1 || mem_rden !== 1'b0) bad++;
                    tick();
                end
                total_cnt++; if (bad != 0) $display("FAIL stall_stable got=%0d exp=0 unstable cycles", bad); else pass_cnt++;
                instr_ready = 1'b1;
                tick();
                instr_ready = 1'b0;
                total_cnt++; if (mem_rden !== 1'b1 || mem_address !== 16'h2)
                    $display("FAIL stall_b2b_issue got=%b/%h exp=1/0002", mem_rden, mem_address); else pass_cnt++;
            end
            wait_hs(20, ok);
            total_cnt++; if (!ok) $display("FAIL stall_hs%0d got=timeout exp=handshake", k); else pass_cnt++;
            if (ok) begin
                e = exp_q.pop_front();
                total_cnt++; if (got_instr[rd_idx] !== e.data) $display("FAIL stall_instr%0d got=%h exp=%h", k, got_instr[rd_idx], e.data); else pass_cnt++;
                total_cnt++; if (got_pc[rd_idx] !== e.pc) $display("FAIL stall_pc%0d got=%h exp=%h", k, got_pc[rd_idx], e.pc); else pass_cnt++;
                rd_idx++;
            end
        end
        fetch_en = 1'b0;
        repeat (4) tick();
        total_cnt++; if (hs_cnt != rd_idx) $display("FAIL stall_extra got=%0d exp=%0d", hs_cnt, rd_idx); else pass_cnt++;
    endtask

    task automatic test_redirect_wait();
        bit ok;
        exp_t e;
        do_reset();
        exp_q.push_back('{32'h0, 32'h0050_0093});
        exp_q.push_back('{32'h4, 32'h00A0_0113});
        exp_q.push_back('{32'h40, mem[16'h10]});
        fetch_en = 1'b1;
        instr_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_rden && mem_address == 16'h2) begin ok = 1'b1; break; end
        end
        tick();
        total_cnt++; if (!ok || fetch_busy !== 1'b1 || mem_rden !== 1'b0)
            $display("FAIL rdw_in_wait got=%b/%b/%b exp=1/1/0", ok, fetch_busy, mem_rden); else pass_cnt++;
        redirect = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        total_cnt++; if (mem_rden !== 1'b1 || mem_address !== 16'h10)
            $display("FAIL rdw_issue got=%b/%h exp=1/0010", mem_rden, mem_address); else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            wait_hs(20, ok);
            total_cnt++; if (!ok) $display("FAIL rdw_hs%0d got=timeout exp=handshake", k); else pass_cnt++;
            if (ok) begin
                e = exp_q.pop_front();
                total_cnt++; if (got_instr[rd_idx] !== e.data) $display("FAIL rdw_instr%0d got=%h exp=%h", k, got_instr[rd_idx], e.data); else pass_cnt++;
                total_cnt++; if (got_pc[rd_idx] !== e.pc) $display("FAIL rdw_pc%0d got=%h exp=%h", k, got_pc[rd_idx], e.pc); else pass_cnt++;
                rd_idx++;
            end
        end
        fetch_en = 1'b0;
        instr_ready = 1'b0;
        repeat (4) tick();
        total_cnt++; if (hs_cnt != rd_idx) $display("FAIL rdw_extra got=%0d exp=%0d", hs_cnt, rd_idx); else pass_cnt++;
    endtask

    task automatic test_redirect_hold();
        bit ok;
        exp_t e;
        do_reset();
        exp_q.push_back('{32'h0, 32'h0050_0093});
        exp_q.push_back('{32'h20, mem[16'h8]});
        fetch_en = 1'b1;
        wait_valid(10, ok);
        instr_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h20;
        tick();
        redirect = 1'b0;
        total_cnt++; if (mem_rden !== 1'b1 || mem_address !== 16'h8)
            $display("FAIL rdh_issue got=%b/%h exp=1/0008", mem_rden, mem_address); else pass_cnt++;
        for (int k = 0; k < 2; k++) begin
            wait_hs(20, ok);
            total_cnt++; if (!ok) $display("FAIL rdh_hs%0d got=timeout exp=handshake", k); else pass_cnt++;
            if (ok) begin
                e = exp_q.pop_front();
                total_cnt++; if (got_instr[rd_idx] !== e.data) $display("FAIL rdh_instr%0d got=%h exp=%h", k, got_instr[rd_idx], e.data); else pass_cnt++;
                total_cnt++; if (got_pc[rd_idx] !== e.pc) $display("FAIL rdh_pc%0d got=%h exp=%h", k, got_pc[rd_idx], e.pc); else pass_cnt++;
                rd_idx++;
            end
        end
        fetch_en = 1'b0;
        instr_ready = 1'b0;
        repeat (4) tick();
        total_cnt++; if (hs_cnt != rd_idx) $display("FAIL rdh_extra got=%0d exp=%0d", hs_cnt, rd_idx); else pass_cnt++;
    endtask

    task automatic test_misaligned();
        bit ok;
        int bad;
        exp_t e;
        do_reset();
        fetch_en = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h22;
        tick();
        redirect = 1'b0;
        total_cnt++; if (misaligned !== 1'b1 || instr_valid !== 1'b0)
            $display("FAIL mis_flag got=%b/%b exp=1/0", misaligned, instr_valid); else pass_cnt++;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            redirect = (k == 5);
            redirect_pc = 32'h40;
            if (mem_rden !== 1'b0 || fetch_busy !== 1'b0) bad++;
            tick();
        end
        redirect = 1'b0;
        total_cnt++; if (bad != 0) $display("FAIL mis_no_fetch got=%0d exp=0 active cycles", bad); else pass_cnt++;
        total_cnt++; if (misaligned !== 1'b1) $display("FAIL mis_sticky got=%b exp=1", misaligned); else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++; if (misaligned !== 1'b0) $display("FAIL mis_reset got=%b exp=0", misaligned); else pass_cnt++;
        tick();
        rst = 1'b0;
        rd_idx = hs_cnt;
        exp_q.push_back('{32'h0, 32'h0050_0093});
        instr_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_rden) begin ok = 1'b1; break; end
        end
        total_cnt++; if (!ok || mem_address !== 16'h0)
            $display("FAIL mis_restart_addr got=%b/%h exp=1/0000", ok, mem_address); else pass_cnt++;
        wait_hs(20, ok);
        total_cnt++; if (!ok) $display("FAIL mis_hs got=timeout exp=handshake"); else pass_cnt++;
        if (ok) begin
            e = exp_q.pop_front();
            total_cnt++; if (got_pc[rd_idx] !== e.pc) $display("FAIL mis_restart_pc got=%h exp=%h", got_pc[rd_idx], e.pc); else pass_cnt++;
            rd_idx++;
        end
        fetch_en = 1'b0;
        instr_ready = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_latency_l2();
        int t_issue, lat, got;
        exp_t e;
        do_reset();
        exp_q.push_back('{32'h0, 32'h0050_0093});
        exp_q.push_back('{32'h4, 32'h00A0_0113});
        fetch_en_b = 1'b1;
        instr_ready_b = 1'b1;
        t_issue = -100;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_rden_b) begin t_issue = cyc; break; end
        end
        lat = -1;
        got = 0;
        for (int i = 0; i < 30 && got < 2; i++) begin
            tick();
            if (instr_valid_b) begin
                if (got == 0) lat = cyc - t_issue;
                e = exp_q.pop_front();
                total_cnt++; if (instr_b !== e.data) $display("FAIL l2_instr%0d got=%h exp=%h", got, instr_b, e.data); else pass_cnt++;
                total_cnt++; if (instr_pc_b !== e.pc) $display("FAIL l2_pc%0d got=%h exp=%h", got, instr_pc_b, e.pc); else pass_cnt++;
                got++;
            end
        end
        fetch_en_b = 1'b0;
        total_cnt++; if (got != 2) $display("FAIL l2_count got=%0d exp=2", got); else pass_cnt++;
        total_cnt++; if (lat != 3) $display("FAIL l2_latency got=%0d exp=3", lat); else pass_cnt++;
        repeat (4) tick();
    endtask

    task automatic test_wrap();
        logic [15:0] iss [0:3];
        int n_iss, got;
        exp_t e;
        do_reset();
        exp_q.push_back('{32'h0003_FFFC, mem[16'hFFFF]});
        exp_q.push_back('{32'h0004_0000, mem[16'h0000]});
        fetch_en_c = 1'b1;
        instr_ready_c = 1'b1;
        n_iss = 0;
        got = 0;
        for (int i = 0; i < 30 && got < 2; i++) begin
            tick();
            if (mem_rden_c && n_iss < 4) begin iss[n_iss] = mem_address_c; n_iss++; end
            if (instr_valid_c) begin
                e = exp_q.pop_front();
                total_cnt++; if (instr_c !== e.data) $display("FAIL wrap_instr%0d got=%h exp=%h", got, instr_c, e.data); else pass_cnt++;
                total_cnt++; if (instr_pc_c !== e.pc) $display("FAIL wrap_pc%0d got=%h exp=%h", got, instr_pc_c, e.pc); else pass_cnt++;
                got++;
            end
        end
        fetch_en_c = 1'b0;
        total_cnt++; if (n_iss != 2) $display("FAIL wrap_issues got=%0d exp=2", n_iss); else pass_cnt++;
        if (n_iss >= 2) begin
            total_cnt++; if (iss[0] !== 16'hFFFF) $display("FAIL wrap_addr0 got=%h exp=ffff", iss[0]); else pass_cnt++;
            total_cnt++; if (iss[1] !== 16'h0000) $display("FAIL wrap_addr1 got=%h exp=0000", iss[1]); else pass_cnt++;
        end
        repeat (4) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'hA500_0000 | 32'(i);
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00A0_0113;
        mem[2] = 32'h0020_81B3;
        test_reset();
        test_stream_l1();
        test_stall_hold();
        test_redirect_wait();
        test_redirect_hold();
        test_misaligned();
        test_latency_l2();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
